// File: rtl/switch_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer_pkg
// Purpose  : Shared types, default parameters and helpers for the switch
//            debouncer front end.
// Contents : deb_state_e    - per-channel debounce FSM states
//            c_default_*    - default parameter values
//            cnt_width()    - debounce counter width for a given cycle count
// Revision : 1.0 - initial release
// ============================================================================
package switch_debouncer_pkg;

    typedef enum logic [0:0] {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_e;

    localparam int c_default_num_ch          = 2;
    localparam int c_default_debounce_cycles = 1_000_000;
    localparam int c_default_sync_stages     = 2;

    // The counter only ever reaches DEBOUNCE_CYCLES-1, so $clog2 suffices;
    // clamp to one bit so a degenerate count still yields a legal vector.
    function automatic int cnt_width(input int debounce_cycles);
        return (debounce_cycles > 2) ? $clog2(debounce_cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer_if
// Purpose  : Bundles the raw switch inputs and the conditioned outputs of
//            the switch debouncer.
// Signals  : sw_in     - raw asynchronous switch levels
//            level_out - debounced levels (bit0 -> a_in, bit1 -> b_in)
//            rise_out  - one-cycle 0->1 pulse per channel
//            fall_out  - one-cycle 1->0 pulse per channel
//            valid_out - startup settling window has elapsed
// Modports : master - board/consumer side, slave - debouncer side
// Revision : 1.0 - initial release
// ============================================================================
interface switch_debouncer_if
    import switch_debouncer_pkg::*;
#(
    parameter int NUM_CH = c_default_num_ch
);
    logic [NUM_CH-1:0] sw_in;
    logic [NUM_CH-1:0] level_out;
    logic [NUM_CH-1:0] rise_out;
    logic [NUM_CH-1:0] fall_out;
    logic              valid_out;

    modport master (
        output sw_in,
        input  level_out,
        input  rise_out,
        input  fall_out,
        input  valid_out
    );

    modport slave (
        input  sw_in,
        output level_out,
        output rise_out,
        output fall_out,
        output valid_out
    );
endinterface
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One switch channel: input synchroniser, two-state debounce FSM
//            with persistence counter, and registered edge pulses.
// Ports    : clk_in   - system clock (posedge)
//            rst_n_in - asynchronous active-low reset
//            i_sw     - raw asynchronous switch level
//            i_valid  - startup window elapsed; gates the edge pulses
//            o_level  - debounced level
//            o_rise   - one-cycle pulse on o_level 0->1
//            o_fall   - one-cycle pulse on o_level 1->0
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
    parameter int SYNC_STAGES     = c_default_sync_stages
) (
    input  wire logic clk_in,
    input  wire logic rst_n_in,
    input  wire logic i_sw,
    input  wire logic i_valid,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);

    localparam int                 c_cnt_w    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_syn;
    deb_state_e             r_state;
    deb_state_e             w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic                   r_level;
    logic                   w_level_nxt;
    logic                   w_toggle;
    logic                   r_rise;
    logic                   r_fall;

    // Synchroniser chain; only the final stage is trusted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
        end
    end

    assign w_syn = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            // Pulses share the edge on which the level flips, and are held
            // off until the startup window has closed.
            r_rise  <= w_toggle &  w_level_nxt & i_valid;
            r_fall  <= w_toggle & ~w_level_nxt & i_valid;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_toggle    = 1'b0;
        case (r_state)
            STABLE: begin
                w_cnt_nxt = '0;
                if (w_syn != r_level) begin
                    w_state_nxt = COUNTING;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            COUNTING: begin
                if (w_syn == r_level) begin
                    // Excursion ended early: discard progress.
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = ~r_level;
                    w_toggle    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Purpose  : Conditions NUM_CH mechanical switches for the adder datapath:
//            synchronises and debounces each channel, emits edge pulses and
//            a startup-settled flag.
// Ports    : clk_in   - system clock (posedge)
//            rst_n_in - asynchronous active-low reset
//            bus      - switch_debouncer_if.slave (sw_in in; level_out,
//                       rise_out, fall_out, valid_out out)
// Revision : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int NUM_CH          = c_default_num_ch,
    parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
    parameter int SYNC_STAGES     = c_default_sync_stages
) (
    input  wire logic         clk_in,
    input  wire logic         rst_n_in,
    switch_debouncer_if.slave bus
);

    // Startup window matches the worst-case time for an input already
    // asserted at reset to reach level_out.
    localparam int                   c_start_total = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int                   c_start_w     = $clog2(c_start_total);
    localparam logic [c_start_w-1:0] c_start_last  = c_start_w'(c_start_total - 1);
    localparam logic [c_start_w-1:0] c_start_one   = c_start_w'(1);

    logic [c_start_w-1:0] r_start_cnt;
    logic                 r_valid;
    logic [NUM_CH-1:0]    w_level;
    logic [NUM_CH-1:0]    w_rise;
    logic [NUM_CH-1:0]    w_fall;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_start_cnt <= '0;
            r_valid     <= 1'b0;
        end else if (!r_valid) begin
            if (r_start_cnt == c_start_last) begin
                r_valid <= 1'b1;
            end else begin
                r_start_cnt <= r_start_cnt + c_start_one;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_channel
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_channel (
                .clk_in   (clk_in),
                .rst_n_in (rst_n_in),
                .i_sw     (bus.sw_in[g]),
                .i_valid  (r_valid),
                .o_level  (w_level[g]),
                .o_rise   (w_rise[g]),
                .o_fall   (w_fall[g])
            );
        end
    endgenerate

    assign bus.level_out = w_level;
    assign bus.rise_out  = w_rise;
    assign bus.fall_out  = w_fall;
    assign bus.valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debouncer
// Purpose  : Self-checking bench for switch_debouncer with a sample-window
//            reference model (a level flips once the last DEBOUNCE_CYCLES
//            synchronised samples all disagree with it).
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int NUM_CH = 2;
    localparam int DEB    = 4;
    localparam int SYNC   = 2;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;

    always #5 clk_in = ~clk_in;

    switch_debouncer_if #(.NUM_CH(NUM_CH)) bus ();

    switch_debouncer #(
        .NUM_CH          (NUM_CH),
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // m_hist[c] bit j holds the raw switch sampled j+1 edges ago (before the
    // current edge's sample is shifted in). The debouncer logic at an edge
    // sees the sample taken SYNC edges earlier, so the DEB samples it has
    // seen most recently are bits SYNC-1 .. SYNC+DEB-2.
    logic [31:0]       m_hist [NUM_CH];
    logic [NUM_CH-1:0] m_level;
    logic [NUM_CH-1:0] m_rise;
    logic [NUM_CH-1:0] m_fall;
    logic              m_valid;
    int                m_edges;

    function automatic logic window_flip(input logic [31:0] h, input logic lvl);
        for (int j = 0; j < DEB; j++) begin
            if (h[SYNC-1+j] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < NUM_CH; c++) m_hist[c] <= '0;
            m_level <= '0;
            m_rise  <= '0;
            m_fall  <= '0;
            m_valid <= 1'b0;
            m_edges <= 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_hist[c] <= {m_hist[c][30:0], bus.sw_in[c]};
                if (window_flip(m_hist[c], m_level[c])) begin
                    m_level[c] <= ~m_level[c];
                    m_rise[c]  <= m_valid & ~m_level[c];
                    m_fall[c]  <= m_valid &  m_level[c];
                end else begin
                    m_rise[c] <= 1'b0;
                    m_fall[c] <= 1'b0;
                end
            end
            m_edges <= m_edges + 1;
            if (m_edges + 1 >= SYNC + DEB) m_valid <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int rise_cycles = 0;
        rst_n_in   = 1'b0;
        bus.sw_in  = 2'b11;
        tick();
        tick();
        n_checks++;
        if ({bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out});
        end
        rst_n_in = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if ({bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out} !==
                {m_level, m_rise, m_fall, m_valid}) begin
                n_errors++;
                $display("FAIL model_reset edge %0d: got %b want %b", e,
                         {bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out},
                         {m_level, m_rise, m_fall, m_valid});
            end
            if (bus.rise_out != '0) rise_cycles++;
            if (e == 5) begin
                n_checks++;
                if ({bus.valid_out, bus.level_out} !== 3'b000) begin
                    n_errors++;
                    $display("FAIL reset_edge5: got valid,level=%b want 000",
                             {bus.valid_out, bus.level_out});
                end
            end
            if (e == 6) begin
                n_checks++;
                if ({bus.valid_out, bus.level_out} !== 3'b111) begin
                    n_errors++;
                    $display("FAIL reset_edge6: got valid,level=%b want 111",
                             {bus.valid_out, bus.level_out});
                end
            end
        end
        n_checks++;
        if (rise_cycles != 0) begin
            n_errors++;
            $display("FAIL reset_no_rise: got %0d rise cycles want 0", rise_cycles);
        end
    endtask

    task automatic test_clean_step();
        bus.sw_in = 2'b00;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if ({bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out} !==
                {m_level, m_rise, m_fall, m_valid}) begin
                n_errors++;
                $display("FAIL model_settle edge %0d: got %b want %b", e,
                         {bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out},
                         {m_level, m_rise, m_fall, m_valid});
            end
        end
        bus.sw_in[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if ({bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out} !==
                {m_level, m_rise, m_fall, m_valid}) begin
                n_errors++;
                $display("FAIL model_step edge %0d: got %b want %b", e,
                         {bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out},
                         {m_level, m_rise, m_fall, m_valid});
            end
            if (e == 5 || e == 6 || e == 7) begin
                logic [1:0] want;
                want = (e == 5) ? 2'b00 : (e == 6) ? 2'b11 : 2'b10;
                n_checks++;
                if ({bus.level_out[0], bus.rise_out[0]} !== want) begin
                    n_errors++;
                    $display("FAIL step_edge%0d: got level0,rise0=%b want %b", e,
                             {bus.level_out[0], bus.rise_out[0]}, want);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int rises = 0;
        int falls = 0;
        int level_hi = 0;
        bus.sw_in[1] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            if (e == 4) bus.sw_in[1] = 1'b0;
            tick();
            if (bus.level_out[1]) level_hi++;
            if (bus.rise_out[1])  rises++;
            if (bus.fall_out[1])  falls++;
        end
        n_checks++;
        if ({level_hi, rises, falls} != '0) begin
            n_errors++;
            $display("FAIL glitch3: got level_hi=%0d rises=%0d falls=%0d want 0 0 0",
                     level_hi, rises, falls);
        end
        bus.sw_in[1] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            if (e == 7) bus.sw_in[1] = 1'b0;
            tick();
            n_checks++;
            if ({bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out} !==
                {m_level, m_rise, m_fall, m_valid}) begin
                n_errors++;
                $display("FAIL model_pulse6 edge %0d: got %b want %b", e,
                         {bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out},
                         {m_level, m_rise, m_fall, m_valid});
            end
            if (bus.rise_out[1]) rises++;
            if (bus.fall_out[1]) falls++;
        end
        n_checks++;
        if (rises != 1 || falls != 1) begin
            n_errors++;
            $display("FAIL pulse6: got rises=%0d falls=%0d want 1 1", rises, falls);
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        int rise_at = -1;
        bus.sw_in[0] = 1'b0;
        for (int e = 1; e <= 10; e++) tick();
        n_checks++;
        if (bus.level_out[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL bounce_prep: got level0=%b want 0", bus.level_out[0]);
        end
        for (int k = 0; k < 4; k++) begin
            bus.sw_in[0] = ~k[0];
            tick();
            if (bus.rise_out[0]) rises++;
        end
        bus.sw_in[0] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            n_checks++;
            if ({bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out} !==
                {m_level, m_rise, m_fall, m_valid}) begin
                n_errors++;
                $display("FAIL model_bounce edge %0d: got %b want %b", e,
                         {bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out},
                         {m_level, m_rise, m_fall, m_valid});
            end
            if (bus.rise_out[0]) begin
                rises++;
                rise_at = e;
            end
        end
        n_checks++;
        if (rises != 1 || rise_at != 6) begin
            n_errors++;
            $display("FAIL bounce: got rises=%0d at edge %0d want 1 at edge 6", rises, rise_at);
        end
    endtask

    task automatic test_simultaneous();
        int hits = 0;
        int hit_at = -1;
        bus.sw_in = 2'b00;
        for (int e = 1; e <= 10; e++) tick();
        bus.sw_in = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (bus.rise_out == 2'b11) begin
                hits++;
                hit_at = e;
            end
        end
        n_checks++;
        if (hits != 1 || hit_at != 6) begin
            n_errors++;
            $display("FAIL simul_rise: got %0d cycles at edge %0d want 1 at edge 6", hits, hit_at);
        end
        n_checks++;
        if ({&bus.level_out, ^bus.level_out} !== 2'b10) begin
            n_errors++;
            $display("FAIL simul_adder: got carry,sum=%b want 10",
                     {&bus.level_out, ^bus.level_out});
        end
    endtask

    task automatic test_reset_mid_count();
        int rise_cycles = 0;
        bus.sw_in = 2'b00;
        for (int e = 1; e <= 10; e++) tick();
        bus.sw_in[0] = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        rst_n_in = 1'b0;
        #1;
        n_checks++;
        if ({bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out} !== 7'b0) begin
            n_errors++;
            $display("FAIL midreset_clear: got %b want 0000000",
                     {bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out});
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if ({bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out} !==
                {m_level, m_rise, m_fall, m_valid}) begin
                n_errors++;
                $display("FAIL model_midreset edge %0d: got %b want %b", e,
                         {bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out},
                         {m_level, m_rise, m_fall, m_valid});
            end
            if (bus.rise_out != '0) rise_cycles++;
            if (e == 5 || e == 6) begin
                logic want;
                want = (e == 6);
                n_checks++;
                if (bus.level_out[0] !== want) begin
                    n_errors++;
                    $display("FAIL midreset_edge%0d: got level0=%b want %b", e,
                             bus.level_out[0], want);
                end
            end
        end
        n_checks++;
        if (rise_cycles != 0) begin
            n_errors++;
            $display("FAIL midreset_no_rise: got %0d rise cycles want 0", rise_cycles);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 60; s++) begin
            bus.sw_in = NUM_CH'($urandom);
            hold = int'($urandom_range(1, 8));
            for (int k = 0; k < hold; k++) begin
                tick();
                n_checks++;
                if ({bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out} !==
                    {m_level, m_rise, m_fall, m_valid}) begin
                    n_errors++;
                    $display("FAIL model_random seg %0d cyc %0d: got %b want %b", s, k,
                             {bus.level_out, bus.rise_out, bus.fall_out, bus.valid_out},
                             {m_level, m_rise, m_fall, m_valid});
                end
            end
        end
    endtask

    initial begin
        bus.sw_in = 2'b00;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
